memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares one single-port synchronous RAM among three requesters: instruction fetch, data load/store, and a program loader. Each access takes two cycles: a grant cycle and a response cycle. Requesters are paced by a per-port ready pulse. The block sits between the core's fetch and data ports and the unified program/data RAM. It lets the core run from one memory instead of separate program and data memories.

## Interface
- Parameters:
- ADDRESS_WIDTH, 32, byte address width on all ports.
- Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- fetch_request  input  1  instruction port requests a read.
- fetch_address  input  ADDRESS_WIDTH  instruction read address.
- fetch_ready  output  1  one-cycle pulse; fetch_read_value valid this cycle.
- fetch_read_value  output  32  RAM word for fetch.
- data_request  input  1  data port requests an access.
- data_address  input  ADDRESS_WIDTH  data address.
- data_write_sections  input  3  bit2 = write high half-word, bit1 = write low half-word high byte, bit0 = write low byte; 0 = read.
- data_write_value  input  32  store data.
- data_ready  output  1  one-cycle pulse; access complete, data_read_value valid.
- data_read_value  output  32  RAM word for data reads.
- loader_request / loader_address / loader_write_sections / loader_write_value  input  1/ADDRESS_WIDTH/3/32  loader port; same encoding as the data port.
- loader_ready  output  1  one-cycle completion pulse.
- mem_address  output  ADDRESS_WIDTH  RAM address.
- mem_write_sections  output  3  RAM write enables; 0 = read.
- mem_write_value  output  32  RAM write data.
- mem_read_value  input  32  RAM read data, valid one cycle after the address is sampled.
- grant_id  output  2  current owner: 0 none, 1 fetch, 2 data, 3 loader.

## Operation
- FSM with two states: IDLE and RESPOND.
- IDLE:
  - If any request is high, select a winner combinationally.
  - Drive mem_address, mem_write_sections and mem_write_value from the winner's inputs.
  - Set grant_id to the winner and go to RESPOND.
  - If no request is high, mem_write_sections = 0, mem_address = 0, grant_id = 0, and the FSM stays in IDLE.
- RESPOND:
  - Pulse the granted port's ready and route mem_read_value to its read_value.
  - Hold mem_write_sections = 0 so the write is not repeated.
  - Return to IDLE; no arbitration happens in this state.
- Priority:
  - loader beats everything.
  - fetch and data alternate round-robin using a last_grant bit, set only when fetch or data wins.
  - When both fetch and data request, the one not granted last wins.
  - last_grant resets to "data", so fetch wins the first contention after reset.
- A loader grant does not change last_grant.
- Handshake:
  - A requester holds request, address, write_sections and write_value stable from assertion through its ready cycle.
  - A requester may drop request in the ready cycle, or keep it high to queue the next access.
  - Behaviour is undefined if a requester drops its request before ready.
- fetch is always a read; the fetch port has no write inputs.
- The read value on a write access is unspecified; the requester ignores it.
- read_value outputs are 0 whenever the corresponding ready is low.
- Reset:
  - Goes to IDLE, last_grant = data.
  - All ready outputs 0, grant_id 0, mem_write_sections 0, mem_address 0, mem_write_value 0.
  - A reset during RESPOND abandons the response: no ready pulse. A write already sampled by the RAM stays committed.

## Timing
- Latency from a granted request to ready: 1 cycle (grant in cycle N, ready in N+1).
- Maximum throughput is one access per 2 cycles.
- One requester alone with continuous requests gets ready every other cycle.
- Fetch and data both requesting continuously: grants go F, D, F, D…, one grant every 2 cycles, so each port gets ready every 4 cycles.
- A continuous loader request starves fetch and data; this is intentional, since the loader runs only while the core is held.
- The mem_* outputs are combinational from the request inputs in IDLE. The RAM samples the address and write enables on the posedge that ends the grant cycle.

## Test plan
- Reset then fetch-only request, fetch_address=0x10, RAM[0x10]=0xDEADBEEF: grant_id=1 in cycle N, fetch_ready=1 with fetch_read_value=0xDEADBEEF in N+1; back-to-back requests give ready every 2nd cycle.
- Fetch and data request in the same cycle after reset: fetch granted first, then data, then fetch. The data read at 0x20 returns the RAM word, and grant_id follows 1,0,2,0,1.
- Data byte write, data_write_sections=3'b001, data_write_value=0x000000AB, address 0x40 preloaded with 0x11223344: mem_write_sections=001 only in the grant cycle, data_ready in the next cycle, a following read returns 0x112233AB.
- Loader, fetch and data all request at once: loader first, then fetch, then data. Check that last_grant is unchanged by the loader grant.
- Reset asserted in the RESPOND cycle of a fetch: no fetch_ready pulse, and all outputs are at their reset values the next cycle. The next request is granted normally.
- Idle with no requests for 5 cycles: mem_write_sections=0, grant_id=0, all ready outputs low, all read_value outputs 0.

Source files
------------

// File: rtl/memory_arbiter.sv
// Arbitrates one single-port synchronous RAM among fetch, data and loader requesters.
// Each access is a grant cycle (mem_* driven) followed by a response cycle (ready pulse).
module memory_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     fetch_request,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_ready,
  output logic [31:0]              fetch_read_value,

  input  logic                     data_request,
  input  logic [ADDRESS_WIDTH-1:0] data_address,
  input  logic [2:0]               data_write_sections,
  input  logic [31:0]              data_write_value,
  output logic                     data_ready,
  output logic [31:0]              data_read_value,

  input  logic                     loader_request,
  input  logic [ADDRESS_WIDTH-1:0] loader_address,
  input  logic [2:0]               loader_write_sections,
  input  logic [31:0]              loader_write_value,
  output logic                     loader_ready,

  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [2:0]               mem_write_sections,
  output logic [31:0]              mem_write_value,
  input  logic [31:0]              mem_read_value,

  output logic [1:0]               grant_id
);

  localparam logic [1:0] GrantNone   = 2'd0;
  localparam logic [1:0] GrantFetch  = 2'd1;
  localparam logic [1:0] GrantData   = 2'd2;
  localparam logic [1:0] GrantLoader = 2'd3;

  typedef enum logic {StIdle, StRespond} state_e;

  state_e     state_q;
  logic [1:0] owner_q;
  // Set when data won the last fetch/data arbitration; loader grants leave it alone.
  logic       last_data_q;
  logic [1:0] winner;
  logic       responding;

  always_comb begin
    winner = GrantNone;
    if (loader_request) begin
      winner = GrantLoader;
    end else if (fetch_request && data_request) begin
      winner = last_data_q ? GrantFetch : GrantData;
    end else if (fetch_request) begin
      winner = GrantFetch;
    end else if (data_request) begin
      winner = GrantData;
    end
  end

  // Reset is gated in so a reset cycle never shows a grant or a ready pulse.
  assign grant_id   = (state_q == StIdle && !reset) ? winner : GrantNone;
  assign responding = (state_q == StRespond) && !reset;

  always_comb begin
    mem_address        = '0;
    mem_write_sections = 3'b000;
    mem_write_value    = 32'h0;
    case (grant_id)
      GrantFetch: begin
        mem_address = fetch_address;
      end
      GrantData: begin
        mem_address        = data_address;
        mem_write_sections = data_write_sections;
        mem_write_value    = data_write_value;
      end
      GrantLoader: begin
        mem_address        = loader_address;
        mem_write_sections = loader_write_sections;
        mem_write_value    = loader_write_value;
      end
      default: ;
    endcase
  end

  assign fetch_ready      = responding && (owner_q == GrantFetch);
  assign data_ready       = responding && (owner_q == GrantData);
  assign loader_ready     = responding && (owner_q == GrantLoader);
  assign fetch_read_value = fetch_ready ? mem_read_value : 32'h0;
  assign data_read_value  = data_ready ? mem_read_value : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= GrantNone;
      last_data_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (winner != GrantNone) begin
            state_q <= StRespond;
            owner_q <= winner;
            if (winner == GrantFetch) last_data_q <= 1'b0;
            if (winner == GrantData)  last_data_q <= 1'b1;
          end
        end
        StRespond: begin
          state_q <= StIdle;
          owner_q <= GrantNone;
        end
        default: begin
          state_q <= StIdle;
          owner_q <= GrantNone;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a RAM model behind the arbiter and a ready-pulse
// scoreboard, plus per-cycle checks of grant_id and the mem_* drive.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_request;
  logic [31:0] fetch_address;
  logic        fetch_ready;
  logic [31:0] fetch_read_value;
  logic        data_request;
  logic [31:0] data_address;
  logic [2:0]  data_write_sections;
  logic [31:0] data_write_value;
  logic        data_ready;
  logic [31:0] data_read_value;
  logic        loader_request;
  logic [31:0] loader_address;
  logic [2:0]  loader_write_sections;
  logic [31:0] loader_write_value;
  logic        loader_ready;
  logic [31:0] mem_address;
  logic [2:0]  mem_write_sections;
  logic [31:0] mem_write_value;
  logic [31:0] mem_read_value;
  logic [1:0]  grant_id;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]  port;
    logic        chk;
    logic [31:0] value;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ram [64];

  always #5 clk = ~clk;

  memory_arbiter #(.ADDRESS_WIDTH(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .fetch_request        (fetch_request),
    .fetch_address        (fetch_address),
    .fetch_ready          (fetch_ready),
    .fetch_read_value     (fetch_read_value),
    .data_request         (data_request),
    .data_address         (data_address),
    .data_write_sections  (data_write_sections),
    .data_write_value     (data_write_value),
    .data_ready           (data_ready),
    .data_read_value      (data_read_value),
    .loader_request       (loader_request),
    .loader_address       (loader_address),
    .loader_write_sections(loader_write_sections),
    .loader_write_value   (loader_write_value),
    .loader_ready         (loader_ready),
    .mem_address          (mem_address),
    .mem_write_sections   (mem_write_sections),
    .mem_write_value      (mem_write_value),
    .mem_read_value       (mem_read_value),
    .grant_id             (grant_id)
  );

  // RAM model: preloaded while reset is high; samples address/enables on posedge.
  always @(posedge clk) begin
    if (reset) begin
      ram[6'h04] <= 32'hDEADBEEF;
      ram[6'h08] <= 32'hCAFEF00D;
      ram[6'h10] <= 32'h11223344;
      mem_read_value <= 32'h0;
    end else begin
      mem_read_value <= ram[mem_address[7:2]];
      if (mem_write_sections[0]) ram[mem_address[7:2]][7:0]   <= mem_write_value[7:0];
      if (mem_write_sections[1]) ram[mem_address[7:2]][15:8]  <= mem_write_value[15:8];
      if (mem_write_sections[2]) ram[mem_address[7:2]][31:16] <= mem_write_value[31:16];
    end
  end

  // Monitor: every ready pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    int n;
    logic [1:0]  port;
    logic [31:0] rv;
    n = int'(fetch_ready) + int'(data_ready) + int'(loader_ready);
    if (n > 0) begin
      port = fetch_ready ? 2'd1 : (data_ready ? 2'd2 : 2'd3);
      rv   = fetch_ready ? fetch_read_value : data_read_value;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: ready on port %0d, none expected", port);
      end else begin
        if (n > 1 || port != sb[0].port || (sb[0].chk && rv !== sb[0].value)) begin
          fails++;
          $display("FAIL sb_ready: port %0d value %h (readies %0d), expected port %0d value %h",
                   port, rv, n, sb[0].port, sb[0].value);
        end
        void'(sb.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] port, input logic chk, input logic [31:0] value);
    exp_t e;
    e.port  = port;
    e.chk   = chk;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gid"}, {30'h0, grant_id}, 32'd0);
    check({tag, "_wsec"}, {29'h0, mem_write_sections}, 32'd0);
    check({tag, "_addr"}, mem_address, 32'd0);
    check({tag, "_wval"}, mem_write_value, 32'd0);
    check({tag, "_rdy"}, {29'h0, fetch_ready, data_ready, loader_ready}, 32'd0);
    check({tag, "_rvals"}, fetch_read_value | data_read_value, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Drive the cycle's inputs first, then check grant_id on the falling edge.
  task automatic expect_gid(input string name, input logic [1:0] gid);
    @(negedge clk);
    check(name, {30'h0, grant_id}, {30'h0, gid});
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    fetch_request = 1'b0;  fetch_address = 32'h0;
    data_request = 1'b0;   data_address = 32'h0;
    data_write_sections = 3'b0;   data_write_value = 32'h0;
    loader_request = 1'b0; loader_address = 32'h0;
    loader_write_sections = 3'b0; loader_write_value = 32'h0;
    do_reset();

    // Idle for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_quiet("idle");
      cyc();
    end

    // Fetch alone, four back-to-back reads: ready every other cycle.
    fetch_request = 1'b1;
    fetch_address = 32'h10;
    for (int k = 0; k < 4; k++) begin
      push(2'd1, 1'b1, 32'hDEADBEEF);
      @(negedge clk);
      check("f_gid_grant", {30'h0, grant_id}, 32'd1);
      check("f_addr", mem_address, 32'h10);
      check("f_no_rdy", {31'h0, fetch_ready}, 32'd0);
      cyc();
      if (k == 3) fetch_request = 1'b0;
      @(negedge clk);
      check("f_rdy", {31'h0, fetch_ready}, 32'd1);
      check("f_gid_resp", {30'h0, grant_id}, 32'd0);
      cyc();
    end

    // Fetch and data together after reset: F, D, F.
    do_reset();
    fetch_request = 1'b1; fetch_address = 32'h10;
    data_request  = 1'b1; data_address  = 32'h20; data_write_sections = 3'b000;
    push(2'd1, 1'b1, 32'hDEADBEEF);
    push(2'd2, 1'b1, 32'hCAFEF00D);
    push(2'd1, 1'b1, 32'hDEADBEEF);
    expect_gid("fd_gid0", 2'd1);
    expect_gid("fd_gid1", 2'd0);
    expect_gid("fd_gid2", 2'd2);
    data_request = 1'b0;
    expect_gid("fd_gid3", 2'd0);
    expect_gid("fd_gid4", 2'd1);
    fetch_request = 1'b0;
    expect_gid("fd_gid5", 2'd0);

    // Loader, fetch and data together: L, F, D.
    do_reset();
    loader_request = 1'b1; loader_address = 32'h10; loader_write_sections = 3'b000;
    fetch_request  = 1'b1; fetch_address  = 32'h10;
    data_request   = 1'b1; data_address   = 32'h20;
    push(2'd3, 1'b0, 32'h0);
    push(2'd1, 1'b1, 32'hDEADBEEF);
    push(2'd2, 1'b1, 32'hCAFEF00D);
    expect_gid("lfd_gid0", 2'd3);
    loader_request = 1'b0;
    expect_gid("lfd_gid1", 2'd0);
    expect_gid("lfd_gid2", 2'd1);
    fetch_request = 1'b0;
    expect_gid("lfd_gid3", 2'd0);
    expect_gid("lfd_gid4", 2'd2);
    data_request = 1'b0;
    expect_gid("lfd_gid5", 2'd0);

    // Reset during the response cycle of a fetch abandons the ready pulse.
    fetch_request = 1'b1; fetch_address = 32'h10;
    expect_gid("rr_gid0", 2'd1);
    reset = 1'b1;
    fetch_request = 1'b0;
    @(negedge clk);
    check("rr_no_rdy", {31'h0, fetch_ready}, 32'd0);
    check("rr_rval", fetch_read_value, 32'd0);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check_quiet("rr_after");
    cyc();
    fetch_request = 1'b1;
    push(2'd1, 1'b1, 32'hDEADBEEF);
    expect_gid("rr_regrant", 2'd1);
    fetch_request = 1'b0;
    expect_gid("rr_resp", 2'd0);

    // Data byte write, then read back the merged word.
    data_request = 1'b1; data_address = 32'h40;
    data_write_sections = 3'b001; data_write_value = 32'h000000AB;
    push(2'd2, 1'b0, 32'h0);
    @(negedge clk);
    check("bw_wsec", {29'h0, mem_write_sections}, 32'd1);
    check("bw_wval", mem_write_value, 32'h000000AB);
    check("bw_addr", mem_address, 32'h40);
    cyc();
    data_request = 1'b0;
    @(negedge clk);
    check("bw_wsec_resp", {29'h0, mem_write_sections}, 32'd0);
    cyc();
    data_request = 1'b1; data_write_sections = 3'b000; data_write_value = 32'h0;
    push(2'd2, 1'b1, 32'h112233AB);
    expect_gid("bw_rd_gid", 2'd2);
    data_request = 1'b0;
    expect_gid("bw_rd_resp", 2'd0);

    // Loader half-word plus byte-1 write, read back through the data port.
    loader_request = 1'b1; loader_address = 32'h40;
    loader_write_sections = 3'b110; loader_write_value = 32'h55667788;
    push(2'd3, 1'b0, 32'h0);
    @(negedge clk);
    check("lw_wsec", {29'h0, mem_write_sections}, 32'd6);
    check("lw_wval", mem_write_value, 32'h55667788);
    cyc();
    loader_request = 1'b0;
    cyc();
    data_request = 1'b1;
    push(2'd2, 1'b1, 32'h556677AB);
    expect_gid("lw_rd_gid", 2'd2);
    data_request = 1'b0;
    cyc();

    for (int i = 0; i < 3; i++) cyc();
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
